// File: rtl/rf_writeback.sv
// Register-file write port arbiter: merges the ALU stream with a FIFO of
// slow-unit results and publishes which registers still have queued writes.
module rf_writeback #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        slow_valid,
  output logic        slow_ready,
  input  logic [4:0]  slow_rd,
  input  logic [31:0] slow_data,
  output logic        rf_we,
  output logic [4:0]  rf_rw,
  output logic [31:0] rf_w,
  output logic [31:0] pending
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [4:0]    rd_q  [DEPTH];
  logic [31:0]   dat_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    starve_q, starve_d;
  logic          we_q, we_d;
  logic [4:0]    rw_q, rw_d;
  logic [31:0]   w_q, w_d;

  logic full, nonempty, push, pop, alu_win;
  logic [31:0] pend_c;

  assign full       = (cnt_q == CW'(DEPTH));
  assign nonempty   = (cnt_q != '0);
  assign slow_ready = !full;
  // r0 writes complete the handshake but are dropped
  assign push       = slow_valid && slow_ready && (slow_rd != 5'd0);
  assign alu_stall  = alu_valid && nonempty &&
                      (starve_q == 4'(STARVE_LIMIT));
  assign alu_win    = alu_valid && !alu_stall;

  always_comb begin
    pop  = 1'b0;
    we_d = 1'b0;
    rw_d = rw_q;
    w_d  = w_q;
    if (alu_win) begin
      we_d = (alu_rd != 5'd0);
      rw_d = alu_rd;
      w_d  = alu_data;
    end else if (nonempty) begin
      pop  = 1'b1;
      we_d = 1'b1;
      rw_d = rd_q[rptr_q];
      w_d  = dat_q[rptr_q];
    end
  end

  always_comb begin
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    starve_d = starve_q;
    if (!nonempty || pop)
      starve_d = 4'd0;
    else if (alu_win && starve_q != 4'(STARVE_LIMIT))
      starve_d = starve_q + 4'd1;
  end

  // Entry i is live when its distance from the read pointer is below count
  always_comb begin
    logic [AW-1:0] off;
    pend_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rptr_q;
      if ({1'b0, off} < cnt_q)
        pend_c[rd_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr_q]  <= slow_rd;
      dat_q[wptr_q] <= slow_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      rw_q     <= '0;
      w_q      <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      rw_q     <= rw_d;
      w_q      <= w_d;
    end
  end

  assign rf_we   = we_q;
  assign rf_rw   = rw_q;
  assign rf_w    = w_q;
  assign pending = pend_c;

endmodule

// File: tb/tb_rf_writeback.sv
// Directed self-checking bench for rf_writeback (DEPTH=4, STARVE_LIMIT=3).
module tb_rf_writeback;

  logic        clk, reset;
  logic        alu_valid, alu_stall;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        slow_valid, slow_ready;
  logic [4:0]  slow_rd;
  logic [31:0] slow_data;
  logic        rf_we;
  logic [4:0]  rf_rw;
  logic [31:0] rf_w;
  logic [31:0] pending;

  int n_cmp = 0;
  int n_err = 0;

  rf_writeback #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .alu_stall(alu_stall),
    .slow_valid(slow_valid), .slow_ready(slow_ready),
    .slow_rd(slow_rd), .slow_data(slow_data),
    .rf_we(rf_we), .rf_rw(rf_rw), .rf_w(rf_w), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    alu_valid  = 1'b0;
    alu_rd     = '0;
    alu_data   = '0;
    slow_valid = 1'b0;
    slow_rd    = '0;
    slow_data  = '0;
  endtask

  int exp_rd[$];
  int exp_d[$];
  int np, nw, cyc;
  logic took;

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    check("rst_we", rf_we, 0);
    check("rst_rw", rf_rw, 0);
    check("rst_w", rf_w, 0);
    check("rst_pend", pending, 0);
    check("rst_rdy", slow_ready, 1);
    check("rst_stall", alu_stall, 0);
    reset = 1'b0;

    // ALU back-to-back
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'(i);
      alu_data  = 32'(i * 'h11);
      tick();
      check("alu_we", rf_we, 1);
      check("alu_rw", rf_rw, 32'(i));
      check("alu_w", rf_w, 32'(i * 'h11));
    end
    idle();
    tick();
    check("alu_idle_we", rf_we, 0);
    check("alu_idle_rw", rf_rw, 4);

    // Fill under ALU traffic, then overflow offer
    alu_valid = 1'b1;
    alu_rd    = 5'd10;
    alu_data  = 32'hA0;
    for (int i = 0; i < 4; i++) begin
      slow_valid = 1'b1;
      slow_rd    = 5'(5 + i);
      slow_data  = 32'((5 + i) << 8);
      #1;
      check("fill_rdy", slow_ready, 1);
      tick();
      check("fill_alu_rw", rf_rw, 10);
    end
    slow_rd   = 5'd9;
    slow_data = 32'h900;
    #1;
    check("full_rdy", slow_ready, 0);
    check("full_pend", pending, 32'h1E0);
    check("full_stall", alu_stall, 1);
    tick();
    check("full_pop_rw", rf_rw, 5);
    check("full_pop_w", rf_w, 32'h500);
    check("full_refused", pending, 32'h1C0);
    check("full_rdy2", slow_ready, 1);
    check("full_stall2", alu_stall, 0);
    tick();
    check("fill_alu2_rw", rf_rw, 10);
    check("fill_alu2_w", rf_w, 32'hA0);
    check("fill_pend9", pending, 32'h3C0);
    idle();
    for (int i = 6; i <= 9; i++) begin
      tick();
      check("drain_we", rf_we, 1);
      check("drain_rw", rf_rw, 32'(i));
      check("drain_w", rf_w, 32'(i << 8));
    end
    tick();
    check("drain_done_we", rf_we, 0);
    check("drain_pend", pending, 0);

    // Starvation bound
    alu_valid  = 1'b1;
    alu_rd     = 5'd13;
    alu_data   = 32'h101;
    slow_valid = 1'b1;
    slow_rd    = 5'd12;
    slow_data  = 32'hC0C0;
    tick();
    check("stv_w1", rf_w, 32'h101);
    slow_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      alu_data = 32'(32'h100 + k);
      #1;
      check("stv_nostall", alu_stall, 0);
      tick();
      check("stv_alu_rw", rf_rw, 13);
      check("stv_alu_w", rf_w, 32'(32'h100 + k));
    end
    alu_data = 32'h105;
    #1;
    check("stv_stall", alu_stall, 1);
    tick();
    check("stv_head_rw", rf_rw, 12);
    check("stv_head_w", rf_w, 32'hC0C0);
    check("stv_unstall", alu_stall, 0);
    tick();
    check("stv_held_rw", rf_rw, 13);
    check("stv_held_w", rf_w, 32'h105);
    idle();
    tick();

    // r0 suppression
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = 32'hDEADBEEF;
    tick();
    check("r0_alu_we", rf_we, 0);
    idle();
    slow_valid = 1'b1;
    slow_rd    = 5'd0;
    slow_data  = 32'h5555;
    #1;
    check("r0_slow_rdy", slow_ready, 1);
    tick();
    check("r0_pend", pending, 0);
    slow_valid = 1'b0;
    tick();
    check("r0_slow_we", rf_we, 0);

    // Wrap-around with interleaved ALU (rd=0) traffic
    np  = 0;
    nw  = 0;
    cyc = 0;
    while ((np < 10 || nw < 10) && cyc < 200) begin
      alu_valid  = (cyc % 3) != 2;
      alu_rd     = 5'd0;
      alu_data   = 32'(cyc);
      slow_valid = (np < 10);
      slow_rd    = 5'(16 + np);
      slow_data  = 32'(32'hA000 + np);
      #1;
      took = slow_valid && slow_ready;
      tick();
      if (took) begin
        exp_rd.push_back(16 + np);
        exp_d.push_back(32'hA000 + np);
        np++;
      end
      if (rf_we) begin
        if (exp_rd.size() == 0) begin
          check("wrap_spurious", rf_we, 0);
        end else begin
          check("wrap_rw", rf_rw, 32'(exp_rd.pop_front()));
          check("wrap_w", rf_w, 32'(exp_d.pop_front()));
          nw++;
        end
      end
      check("wrap_cnt", 32'($countones(pending) <= 4), 1);
      cyc++;
    end
    check("wrap_written", nw, 10);
    idle();
    tick();

    // Reset mid-stream with 3 queued entries
    alu_valid = 1'b1;
    alu_rd    = 5'd3;
    alu_data  = 32'h33;
    for (int i = 0; i < 3; i++) begin
      slow_valid = 1'b1;
      slow_rd    = 5'(20 + i);
      slow_data  = 32'(i);
      tick();
    end
    slow_valid = 1'b0;
    check("pre_rst_pend", pending, 32'h700000);
    check("pre_rst_we", rf_we, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_we", rf_we, 0);
    check("mid_rst_pend", pending, 0);
    check("mid_rst_rdy", slow_ready, 1);
    check("mid_rst_rw", rf_rw, 0);
    idle();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_we", rf_we, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Write-side front end for the CPU's 32x32 register file, and the only driver of the file's write port (RW/W/WE).
- Merges two result sources onto that single write port:
  - the single-cycle ALU result stream;
  - a valid/ready stream from long-latency units (load unit, multiply/divide).
- Buffers slow-source results in a small FIFO and guarantees those results are not starved.
- Publishes a per-register pending mask that the decode stage uses for hazard stalls.

Parameters:
- DEPTH, 4: slow-result FIFO entries; power of two, 2..16.
- STARVE_LIMIT, 3: number of consecutive cycles the FIFO head may lose to the ALU before the ALU is stalled; range 1..15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_stall  out  1  ALU result not consumed this cycle; upstream holds alu_* stable.
- slow_valid  in  1  slow-unit result offered.
- slow_ready  out  1  block can accept a slow-unit result.
- slow_rd  in  5  slow-unit destination register.
- slow_data  in  32  slow-unit result.
- rf_we  out  1  register-file write enable (registered).
- rf_rw  out  5  register-file write address (registered).
- rf_w  out  32  register-file write data (registered).
- pending  out  32  bit n = 1 while the FIFO holds any write to register n.

Behaviour:
- Reset (asynchronous, immediate):
  - FIFO empty, starve counter = 0.
  - rf_we = 0, rf_rw = 0, rf_w = 0, pending = 0, alu_stall = 0, slow_ready = 1.
  - Reset mid-operation discards all queued results; nothing is written after reset asserts.
- slow_ready = !full. It is combinational from FIFO state only and does not depend on slow_valid or the current pop.
  - Full FIFO with a pop in the same cycle still refuses a push.
- Push: on posedge when slow_valid && slow_ready.
  - slow_rd == 0: the handshake completes but nothing is enqueued (r0 is read-only).
- alu_stall = alu_valid && fifo_nonempty && (starve_cnt == STARVE_LIMIT). It is combinational.
- Each posedge, exactly one write source is selected:
  1. alu_valid && !alu_stall: rf_we <= (alu_rd != 0), rf_rw <= alu_rd, rf_w <= alu_data.
  2. Else if the FIFO is non-empty: pop the head; rf_we <= 1, rf_rw/rf_w <= head.
  3. Else: rf_we <= 0; rf_rw/rf_w hold their previous values.
- The register file commits on the following negedge. Readers therefore see the value in the same cycle rf_we is high, after the negedge.
- Latency:
  - ALU result: 1 cycle to rf_we.
  - Slow result into an empty FIFO with no ALU traffic: pushed at edge N, written at edge N+1.
  - With ALU traffic, bounded by STARVE_LIMIT+1 cycles per entry ahead of it.
- Starve counter:
  - Increments when the FIFO is non-empty and the ALU wins.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- FIFO order is strict first-in first-out. Pointers wrap modulo DEPTH; a count register of width log2(DEPTH)+1 distinguishes full from empty.
- pending is the OR of one-hot decodes of the rd field of every valid FIFO entry. It is combinational from registered state.
  - An entry pushed at edge N shows in pending after edge N.
  - An entry popped at edge N clears (if it is the last entry for that rd) after edge N.
- Ordering: no reordering beyond the priority above. Decode must stall on pending[rs] / pending[rd] to avoid WAW/RAW; this block does not check that.
- Simultaneous push and pop of the same rd is legal; pending stays set for that rd.

Test Plan:
1. Reset check: assert reset mid-stream with 3 entries queued → rf_we = 0 and pending = 0 immediately, slow_ready = 1, no further writes after release.
2. ALU only, 4 back-to-back results (rd = 1..4, data 0x11..0x44) → rf_we high for 4 cycles, each 1 cycle after input, rf_rw = 1..4 in order.
3. Fill and overflow: push 4 slow results (rd = 5..8) with alu_valid held high → slow_ready = 0 after the 4th push, pending = 0x000001E0, a 5th offer is held.
4. Starvation (STARVE_LIMIT = 3): continuous ALU traffic plus 1 queued entry → ALU wins 3 cycles, then alu_stall = 1 for one cycle while the FIFO head writes; the ALU value is written the next cycle, unchanged.
5. r0 suppression: ALU rd = 0 data 0xDEADBEEF → rf_we = 0. Slow rd = 0 → handshake completes, FIFO count unchanged, pending[0] = 0.
6. Wrap-around: 10 slow pushes interleaved with pops at DEPTH = 4 → all 10 written in push order with correct data; count never exceeds 4.
